// File: rtl/periferico_bcd_binario_pkg.sv
// Shared constants, FSM encoding and digit helpers for the BCD-to-binary peripheral.
// Optional digit validation is enabled by defining BCD_DIGIT_CHECK_EN.
package periferico_bcd_binario_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned RES_W  = 14;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DIGITS = 4;

  localparam logic [ADDR_W-1:0] ADDR_BCD_IN = 6'h04;
  localparam logic [ADDR_W-1:0] ADDR_INIT   = 6'h08;
  localparam logic [ADDR_W-1:0] ADDR_RESULT = 6'h0C;
  localparam logic [ADDR_W-1:0] ADDR_DONE   = 6'h10;
  localparam logic [ADDR_W-1:0] ADDR_ERR    = 6'h14;

  localparam logic [CNT_W-1:0] ITERATIONS = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // After a right shift, a nibble >= 8 received a carry worth 8 that must be worth 5.
  function automatic logic [DATA_W-1:0] bcd_adjust(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (d[4*i +: 4] >= 4'd8) r[4*i +: 4] = d[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

  function automatic logic digits_valid(input logic [DATA_W-1:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (d[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/periferico_bcd_binario_if.sv
// Register bus of the BCD-to-binary peripheral; master drives, slave answers.
interface periferico_bcd_binario_if;
  import periferico_bcd_binario_pkg::*;

  logic [DATA_W-1:0] d_in;
  logic              cs;
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] d_out;

  modport master (output d_in, cs, addr, rd, wr, input d_out);
  modport slave  (input d_in, cs, addr, rd, wr, output d_out);
endinterface

// File: rtl/periferico_bcd_binario_bcd_a_binario.sv
// Sequential 4-digit BCD to binary converter (reverse double dabble, 16 shift steps).
// With BCD_DIGIT_CHECK_EN, a non-decimal digit flags ERR and skips the shift phase.
module bcd_a_binario
  import periferico_bcd_binario_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic [DATA_W-1:0] BCD,
  input  logic              INIT,
  output logic [RES_W-1:0]  RESULT,
  output logic              DONE,
  output logic              ERR
);

  state_e              state_q;
  logic [DATA_W-1:0]   digits_q;
  // Two guard bits above the 14-bit result so 16 shifts leave the value right-aligned.
  logic [DATA_W-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] shifted_c;

  assign shifted_c = {digits_q, acc_q} >> 1;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      digits_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      RESULT   <= '0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (INIT) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          digits_q <= BCD;
          acc_q    <= '0;
          cnt_q    <= ITERATIONS;
          DONE     <= 1'b0;
          ERR      <= 1'b0;
          state_q  <= ST_SHIFT;
`ifdef BCD_DIGIT_CHECK_EN
          if (!digits_valid(BCD)) begin
            ERR     <= 1'b1;
            state_q <= ST_FIN;
          end
`endif
        end
        ST_SHIFT: begin
          digits_q <= bcd_adjust(shifted_c[2*DATA_W-1:DATA_W]);
          acc_q    <= shifted_c[DATA_W-1:0];
          cnt_q    <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_q <= ST_FIN;
        end
        ST_FIN: begin
          // An error path reaches here with the accumulator still cleared.
          RESULT  <= acc_q[RES_W-1:0];
          DONE    <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/periferico_bcd_binario.sv
// Bus front-end of the BCD-to-binary peripheral: address decode, operand/start registers, read mux.
// Defining BCD_DIGIT_CHECK_EN exposes the ERR register at 0x14.
module periferico_bcd_binario
  import periferico_bcd_binario_pkg::*;
(
  input  logic                     CLK,
  input  logic                     reset,
  periferico_bcd_binario_if.slave  bus
);

  logic [DATA_W-1:0] bcd_in_q;
  logic              init_q;
  logic              busy_q;
  logic              done_prev_q;
  logic [DATA_W-1:0] d_out_q;

  logic [RES_W-1:0]  result_c;
  logic              done_c;
  logic              err_c;
  logic              wr_en_c;
  logic              busy_c;
  logic              start_c;
  logic              load_bcd_c;
  logic [DATA_W-1:0] rdata_c;
  logic              unused_rd;

  assign unused_rd = bus.rd;

  // The converter is busy from an accepted start until DONE rises; the rise frees the bus that same cycle.
  assign busy_c     = busy_q & ~(done_c & ~done_prev_q);
  assign wr_en_c    = bus.cs & bus.wr;
  assign start_c    = wr_en_c & (bus.addr == ADDR_INIT) & bus.d_in[0] & ~busy_c;
  assign load_bcd_c = wr_en_c & (bus.addr == ADDR_BCD_IN) & ~busy_c;

  always_comb begin
    rdata_c = '0;
    case (bus.addr)
      ADDR_RESULT: rdata_c = DATA_W'(result_c);
      ADDR_DONE:   rdata_c = DATA_W'(done_c);
`ifdef BCD_DIGIT_CHECK_EN
      ADDR_ERR:    rdata_c = DATA_W'(err_c);
`endif
      default:     rdata_c = '0;
    endcase
  end

`ifndef BCD_DIGIT_CHECK_EN
  logic unused_err;
  assign unused_err = err_c;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      bcd_in_q    <= '0;
      init_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_prev_q <= 1'b0;
      d_out_q     <= '0;
    end else begin
      init_q      <= start_c;
      busy_q      <= start_c | busy_c;
      done_prev_q <= done_c;
      if (load_bcd_c) bcd_in_q <= bus.d_in;
      if (bus.cs)     d_out_q  <= rdata_c;
    end
  end

  assign bus.d_out = d_out_q;

  bcd_a_binario u_conv (
    .CLK    (CLK),
    .reset  (reset),
    .BCD    (bcd_in_q),
    .INIT   (init_q),
    .RESULT (result_c),
    .DONE   (done_c),
    .ERR    (err_c)
  );

endmodule
